// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU request/response signals and the word-wide memory port
// of mem_access_unit. The unit itself connects through the slave modport;
// the CPU/memory environment connects through the master modport.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU request side
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  // CPU response side
  logic              busy;
  logic              done;
  logic              misaligned;
  logic [DATA_W-1:0] rdata;
  // memory side
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_Write_data;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] Mem_data;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, Mem_data,
    output busy, done, misaligned, rdata,
    output Mem_Address, Mem_Write_data, MemRead, MemWrite
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, Mem_data,
    input  busy, done, misaligned, rdata,
    input  Mem_Address, Mem_Write_data, MemRead, MemWrite
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer. Turns byte/halfword/word requests into
// word-aligned memory cycles; sub-word stores use read-modify-write and
// loads return the selected lane sign- or zero-extended.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              sign_q;
  logic              mis_reg;
  logic [DATA_W-1:0] merge_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              illegal;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged_word;
  logic [3:0]        lane_hit;

  // Request legality is judged on the live inputs at the accepting edge.
  assign illegal = (bus.size == 2'b11) ||
                   (bus.size == SZ_HALF && bus.addr[0]) ||
                   (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00);

  // Lane extraction for loads: byte lane k at [8k+7:8k], halfword lane h at [16h+15:16h].
  always_comb begin
    byte_sel = bus.Mem_data[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? bus.Mem_data[31:16] : bus.Mem_data[15:0];
    load_val = bus.Mem_data;
    case (size_q)
      SZ_BYTE: load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{sign_q & half_sel[15]}}, half_sel};
      default: load_val = bus.Mem_data;
    endcase
  end

  // Per-lane merge for read-modify-write: a targeted lane takes store data,
  // the others keep the word just read from memory.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_hit[gi] = (size_q == SZ_BYTE && addr_q[1:0] == LANE) ||
                            (size_q == SZ_HALF && addr_q[1] == LANE[1]);
      assign merged_word[8*gi +: 8] =
        !lane_hit[gi]       ? bus.Mem_data[8*gi +: 8] :
        (size_q == SZ_BYTE) ? wdata_q[7:0] :
                              wdata_q[8*(gi % 2) +: 8];
    end
  endgenerate

  // Next-state selection; req only matters in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          if (illegal)                 state_next = DONE;
          else if (!bus.we)            state_next = RD;
          else if (bus.size == SZ_WORD) state_next = WR;
          else                         state_next = RMW_RD;
        end
      end
      RD:      state_next = DONE;
      RMW_RD:  state_next = WR;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; asynchronous reset drops MemRead/MemWrite immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Request latches, merged store word and load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      mis_reg   <= 1'b0;
      merge_reg <= '0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            size_q  <= bus.size;
            we_q    <= bus.we;
            sign_q  <= bus.sign_ext;
            mis_reg <= illegal;
          end
        end
        RD:      rdata_reg <= load_val;
        RMW_RD:  merge_reg <= merged_word;
        default: ;
      endcase
    end
  end

  assign bus.busy           = (state_reg != IDLE);
  assign bus.done           = (state_reg == DONE);
  assign bus.misaligned     = (state_reg == DONE) && mis_reg;
  assign bus.rdata          = rdata_reg;
  assign bus.MemRead        = (state_reg == RD) || (state_reg == RMW_RD);
  assign bus.MemWrite       = (state_reg == WR);
  assign bus.Mem_Address    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.Mem_Write_data = (we_q && size_q == SZ_WORD) ? wdata_q : merge_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit. A byte-addressed
// reference memory predicts load results, store effects, latency and the
// number of memory read/write cycles; a monitor checks each completion.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic clk;
  logic reset;

  mem_access_unit_if mau_if ();

  mem_access_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mau_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: 64 words, combinational read, write on the clock edge.
  logic [31:0] tb_mem [64];
  assign mau_if.Mem_data = tb_mem[mau_if.Mem_Address[7:2]];
  always @(posedge clk) begin
    if (mau_if.MemWrite) tb_mem[mau_if.Mem_Address[7:2]] <= mau_if.Mem_Write_data;
  end

  // Reference model state: byte-addressed memory and last load result.
  logic [7:0]  ref_bytes [256];
  logic [31:0] last_rdata;

  typedef struct {
    int          id;
    logic        mis;
    logic [31:0] rdata;
    int          lat;
    int          reads;
    int          writes;
    int          widx;
    logic [31:0] word;
    time         t0;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   txn_id = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_bytes[4*widx+3], ref_bytes[4*widx+2], ref_bytes[4*widx+1], ref_bytes[4*widx]};
  endfunction

  // Behavioural view: a request touches n consecutive bytes; loads assemble
  // them little-endian, stores overwrite them.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int n;
    int base;
    logic [31:0] v;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = int'(addr[7:0]);
    e.widx = base / 4;
    e.mis = 1'b0;
    if (size == 2'd3 || (base % n) != 0) begin
      e.mis = 1'b1; e.lat = 1; e.reads = 0; e.writes = 0;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base+i]) << (8*i));
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      last_rdata = v;
      e.lat = 2; e.reads = 1; e.writes = 0;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[base+i] = wdata[8*i +: 8];
      e.lat = (n == 4) ? 2 : 3; e.reads = (n == 4) ? 0 : 1; e.writes = 1;
    end
    e.rdata = last_rdata;
    e.word  = ref_word(e.widx);
    return e;
  endfunction

  // Wait (bounded) until the unit is idle at a falling edge.
  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (mau_if.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (mau_if.busy) check("idle_timeout", 32'(mau_if.busy), 32'h0);
  endtask

  // Issue one request; hold keeps req high one extra cycle (ignored while busy).
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
    exp_t e;
    wait_idle();
    mau_if.req = 1'b1; mau_if.we = we; mau_if.size = size;
    mau_if.sign_ext = sgn; mau_if.addr = addr; mau_if.wdata = wdata;
    @(posedge clk);
    e = model(we, size, sgn, addr, wdata);
    e.id = txn_id++;
    e.t0 = $time;
    sb_q.push_back(e);
    @(negedge clk);
    if (hold) @(negedge clk);
    mau_if.req = 1'b0;
    mau_if.addr = $urandom;
    mau_if.wdata = $urandom;
  endtask

  // Monitor: counts memory cycles and checks each completion against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mau_if.MemRead || mau_if.MemWrite)
        check("rd_wr_exclusive", 32'(mau_if.MemRead & mau_if.MemWrite), 32'h0);
      if (mau_if.MemRead)  rd_cnt++;
      if (mau_if.MemWrite) wr_cnt++;
      if (mau_if.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(mau_if.done), 32'h0);
        end else begin
          e = sb_q.pop_front();
          lat = int'(($time - e.t0 + 5) / 10);
          $display("txn %0d: mis=%0b rdata=%08h lat=%0d rd=%0d wr=%0d mem[%0d]=%08h",
                   e.id, mau_if.misaligned, mau_if.rdata, lat, rd_cnt, wr_cnt,
                   e.widx, tb_mem[e.widx]);
          check("misaligned", 32'(mau_if.misaligned), 32'(e.mis));
          check("rdata", mau_if.rdata, e.rdata);
          check("latency", 32'(lat), 32'(e.lat));
          check("read_cycles", 32'(rd_cnt), 32'(e.reads));
          check("write_cycles", 32'(wr_cnt), 32'(e.writes));
          check("mem_word", tb_mem[e.widx], e.word);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Directed table from the worked examples, then random traffic.
  localparam int ND = 15;
  logic        d_we   [ND] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
  logic [1:0]  d_size [ND] = '{0, 0, 0, 1, 1, 2, 0, 1, 2, 2, 2, 2, 1, 3, 2};
  logic        d_sgn  [ND] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic [31:0] d_addr [ND] = '{32'h41, 32'h41, 32'h40, 32'h42, 32'h42, 32'h40, 32'h43, 32'h40,
                               32'h40, 32'h44, 32'h44, 32'h42, 32'h41, 32'h40, 32'h44};
  logic [31:0] d_wd   [ND] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345677,
                               32'hCAFE, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        d_hold [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    logic [31:0] w;
    logic [1:0]  sz;
    logic        we_r;
    int k;
    for (int i = 0; i < 64; i++) begin
      w = (i == 16) ? 32'h8899AABB : $urandom;
      tb_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = w[8*b +: 8];
    end
    last_rdata = 32'h0;
    reset = 1'b0;
    mau_if.req = 1'b0; mau_if.we = 1'b0; mau_if.size = 2'b00;
    mau_if.sign_ext = 1'b0; mau_if.addr = 32'h0; mau_if.wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(mau_if.busy), 32'h0);
    check("rst_done", 32'(mau_if.done), 32'h0);
    check("rst_misaligned", 32'(mau_if.misaligned), 32'h0);
    check("rst_memread", 32'(mau_if.MemRead), 32'h0);
    check("rst_memwrite", 32'(mau_if.MemWrite), 32'h0);
    check("rst_rdata", mau_if.rdata, 32'h0);
    check("rst_mem_address", mau_if.Mem_Address, 32'h0);
    check("rst_mem_write_data", mau_if.Mem_Write_data, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < ND; i++)
      issue(d_we[i], d_size[i], d_sgn[i], d_addr[i], d_wd[i], d_hold[i]);

    for (int i = 0; i < 300; i++) begin
      we_r = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(we_r, sz, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
            !we_r && ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a sub-word store: no write may reach memory.
    wait_idle();
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    mau_if.req = 1'b1; mau_if.we = 1'b1; mau_if.size = 2'b00;
    mau_if.addr = 32'h40; mau_if.wdata = 32'h5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    mau_if.req = 1'b0;
    check("rmw_read_active", 32'(mau_if.MemRead), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("rstmid_busy", 32'(mau_if.busy), 32'h0);
    check("rstmid_memwrite", 32'(mau_if.MemWrite), 32'h0);
    check("rstmid_done", 32'(mau_if.done), 32'h0);
    check("rstmid_rdata", mau_if.rdata, 32'h0);
    last_rdata = 32'h0;
    @(negedge clk);
    #1 reset = 1'b1;
    check("rstmid_mem_word", tb_mem[16], ref_word(16));

    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 1'b0);

    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
